// File: rtl/req_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : req_grant_arbiter
//  Purpose  : Round-robin N:1 request/grant arbiter in front of one shared
//             resource. In IDLE a request is forwarded combinationally, so a
//             transfer can finish with zero wait cycles. If the resource does
//             not grant at once, the winner is locked until the transfer is
//             granted or the request is withdrawn.
//  Ports    : clk          - clock, rising edge
//             rst_n        - asynchronous active-low reset
//             s_req        - per-requester request, held until granted
//             s_grant      - per-requester grant (one-hot or zero)
//             s_payload    - returned payload, valid while any s_grant is high
//             m_req        - request to the shared resource
//             m_grant      - grant from the shared resource
//             m_payload    - payload from the shared resource
//             busy         - high while a transfer is locked
//             sel_id       - index of the requester currently forwarded
//             timeout_err  - sticky timeout flag
//  Options  : REQ_GRANT_ARB_TIMEOUT_EN - when defined, a locked transfer is
//             abandoned after timeout_cycles cycles without m_grant, and
//             timeout_err is set until reset.
//  Revision : 1.0 - initial release
// ============================================================================
module req_grant_arbiter #(
    parameter int req_n          = 2,
    parameter int payload_width  = 32,
    parameter int timeout_cycles = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [req_n-1:0]         s_req,
    output logic [req_n-1:0]         s_grant,
    output logic [payload_width-1:0] s_payload,
    output logic                     m_req,
    input  logic                     m_grant,
    input  logic [payload_width-1:0] m_payload,
    output logic                     busy,
    output logic [1:0]               sel_id,
    output logic                     timeout_err
);

    localparam logic       c_IDLE  = 1'b0;
    localparam logic       c_LOCK  = 1'b1;
    localparam logic [2:0] c_REQ_N = 3'(req_n);

    if (req_n < 2 || req_n > 4 || timeout_cycles < 1 || timeout_cycles > 65535) begin : g_bad_cfg
        $error("req_grant_arbiter: illegal parameter setting");
    end

    logic       r_state;
    logic       w_state_nxt;
    logic [1:0] r_rr_ptr;
    logic [1:0] w_rr_ptr_nxt;
    logic [1:0] r_sel;
    logic [1:0] w_sel_nxt;

    logic [3:0] w_req_ext;      // s_req widened so 2-bit indices are always in range
    logic [1:0] w_scan_idx;
    logic       w_found;
    logic [1:0] w_winner;
    logic [1:0] w_fwd_idx;
    logic [3:0] w_grant_ext;
    logic       w_timeout_hit;

    // (base + off) mod req_n, valid for base, off < req_n
    function automatic logic [1:0] f_wrap_add(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= c_REQ_N) begin
            sum = sum - c_REQ_N;
        end
        return sum[1:0];
    endfunction

    // ------------------------------------------------------------------
    // Round-robin winner search starting at rr_ptr
    // ------------------------------------------------------------------
    always_comb begin
        w_req_ext              = '0;
        w_req_ext[req_n-1:0]   = s_req;
        w_found                = 1'b0;
        w_winner               = 2'd0;
        w_scan_idx             = 2'd0;
        for (int i = 0; i < req_n; i++) begin
            w_scan_idx = f_wrap_add(r_rr_ptr, 2'(i));
            if (!w_found && w_req_ext[w_scan_idx]) begin
                w_found  = 1'b1;
                w_winner = w_scan_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_rr_ptr <= 2'd0;
            r_sel    <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_sel    <= w_sel_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_sel_nxt    = r_sel;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    if (m_grant) begin
                        w_rr_ptr_nxt = f_wrap_add(w_winner, 2'd1);
                    end else begin
                        w_state_nxt = c_LOCK;
                        w_sel_nxt   = w_winner;
                    end
                end
            end
            c_LOCK: begin
                // A withdrawn request abandons the transfer without moving
                // the pointer, so that requester keeps its priority.
                if (!w_req_ext[r_sel]) begin
                    w_state_nxt = c_IDLE;
                end else if (m_grant) begin
                    w_state_nxt  = c_IDLE;
                    w_rr_ptr_nxt = f_wrap_add(r_sel, 2'd1);
                end else if (w_timeout_hit) begin
                    w_state_nxt  = c_IDLE;
                    w_rr_ptr_nxt = f_wrap_add(r_sel, 2'd1);
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        m_req     = 1'b0;
        w_fwd_idx = 2'd0;
        sel_id    = 2'd0;
        busy      = 1'b0;
        case (r_state)
            c_IDLE: begin
                m_req     = w_found;
                w_fwd_idx = w_winner;
                sel_id    = w_winner;
            end
            c_LOCK: begin
                m_req     = w_req_ext[r_sel];
                w_fwd_idx = r_sel;
                sel_id    = r_sel;
                busy      = 1'b1;
            end
            default: begin
                m_req = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_grant_ext = '0;
        if (m_grant && m_req) begin
            w_grant_ext[w_fwd_idx] = 1'b1;
        end
        s_grant = w_grant_ext[req_n-1:0];
    end

    assign s_payload = m_payload;

    // ------------------------------------------------------------------
    // Optional LOCK timeout
    // ------------------------------------------------------------------
`ifdef REQ_GRANT_ARB_TIMEOUT_EN
    localparam logic [16:0] c_TIMEOUT = 17'(timeout_cycles);

    logic [15:0] r_lock_cnt;
    logic [15:0] w_lock_cnt_nxt;
    logic        r_timeout_err;
    logic        w_timeout_err_nxt;

    // r_lock_cnt holds the number of LOCK cycles already completed; it is
    // held at zero in IDLE, which clears it on entry to LOCK.
    assign w_timeout_hit = (r_state == c_LOCK) &&
                           (({1'b0, r_lock_cnt} + 17'd1) == c_TIMEOUT);

    always_comb begin
        w_lock_cnt_nxt    = (r_state == c_LOCK) ? (r_lock_cnt + 16'd1) : 16'd0;
        w_timeout_err_nxt = r_timeout_err;
        if (w_timeout_hit && w_req_ext[r_sel] && !m_grant) begin
            w_timeout_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_cnt    <= 16'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_lock_cnt    <= w_lock_cnt_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_req_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_req_grant_arbiter
//  Purpose  : Self-checking bench for req_grant_arbiter: a table of directed
//             vectors, hand-written multi-cycle sequences (drop, reset in
//             LOCK, timeout) and randomized traffic compared against a
//             behavioural arbiter model.
//  Options  : REQ_GRANT_ARB_TIMEOUT_EN - enables the timeout sequence and
//             timeout behaviour in the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_req_grant_arbiter;

    localparam int N  = 3;
    localparam int PW = 32;
    localparam int TO = 4;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  s_req;
    logic [N-1:0]  s_grant;
    logic [PW-1:0] s_payload;
    logic          m_req;
    logic          m_grant;
    logic [PW-1:0] m_payload;
    logic          busy;
    logic [1:0]    sel_id;
    logic          timeout_err;

    req_grant_arbiter #(
        .req_n          (N),
        .payload_width  (PW),
        .timeout_cycles (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_req       (s_req),
        .s_grant     (s_grant),
        .s_payload   (s_payload),
        .m_req       (m_req),
        .m_grant     (m_grant),
        .m_payload   (m_payload),
        .busy        (busy),
        .sel_id      (sel_id),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit md_locked;
    int md_owner;
    int md_ptr;
    int md_cnt;
    bit md_err;
    int md_to_owner;   // requester whose lock timed out this cycle, else -1

    task automatic mdl_reset();
        md_locked   = 1'b0;
        md_owner    = 0;
        md_ptr      = 0;
        md_cnt      = 0;
        md_err      = 1'b0;
        md_to_owner = -1;
    endtask

    function automatic int mdl_winner(input logic [N-1:0] req);
        for (int off = 0; off < N; off++) begin
            if (req[(md_ptr + off) % N]) return (md_ptr + off) % N;
        end
        return -1;
    endfunction

    task automatic mdl_expect(output logic [N-1:0] eg, output logic emr,
                              output logic eb, output logic [1:0] es);
        int w;
        int f;
        w = mdl_winner(s_req);
        if (!md_locked) begin
            emr = (w >= 0);
            f   = (w >= 0) ? w : 0;
            eb  = 1'b0;
        end else begin
            emr = s_req[md_owner];
            f   = md_owner;
            eb  = 1'b1;
        end
        es = 2'(f);
        eg = (m_grant && emr) ? N'(1 << f) : '0;
    endtask

    task automatic mdl_clock();
        int w;
        w = mdl_winner(s_req);
        md_to_owner = -1;
        if (!md_locked) begin
            if (w >= 0) begin
                if (m_grant) md_ptr = (w + 1) % N;
                else begin
                    md_locked = 1'b1;
                    md_owner  = w;
                    md_cnt    = 0;
                end
            end
        end else if (!s_req[md_owner]) begin
            md_locked = 1'b0;
        end else if (m_grant) begin
            md_locked = 1'b0;
            md_ptr    = (md_owner + 1) % N;
        end else begin
`ifdef REQ_GRANT_ARB_TIMEOUT_EN
            md_cnt++;
            if (md_cnt == TO) begin
                md_locked   = 1'b0;
                md_err      = 1'b1;
                md_ptr      = (md_owner + 1) % N;
                md_to_owner = md_owner;
            end
`endif
        end
    endtask

    // Called at posedge+1: drive, settle to the falling edge, compare.
    task automatic drive_check(input logic [N-1:0] r, input logic g, output logic [N-1:0] eg);
        logic       emr;
        logic       eb;
        logic [1:0] es;
        s_req     = r;
        m_grant   = g;
        m_payload = $urandom;
        #4;
        mdl_expect(eg, emr, eb, es);
        check("s_grant", 32'(s_grant), 32'(eg));
        check("m_req", 32'(m_req), 32'(emr));
        check("busy", 32'(busy), 32'(eb));
        check("sel_id", 32'(sel_id), 32'(es));
        check("s_payload", s_payload, m_payload);
        check("timeout_err", 32'(timeout_err), 32'(md_err));
    endtask

    task automatic tick();
        mdl_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        logic [N-1:0] eg;
        rst_n = 1'b0;
        mdl_reset();
        drive_check('0, 1'b0, eg);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [N-1:0] req;
        logic         mg;
        logic [31:0]  pay;
        logic [N-1:0] g;
        logic         mr;
        logic         b;
        logic [1:0]   sel;
    } vec_t;

    vec_t tbl[14];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [N-1:0] eg;
        int           wait_cnt[N];
        logic [N-1:0] pend;

        tbl[0]  = '{3'b001, 1'b1, 32'h7C0,  3'b001, 1'b1, 1'b0, 2'd0};
        tbl[1]  = '{3'b011, 1'b0, 32'h0,    3'b000, 1'b1, 1'b0, 2'd1};
        tbl[2]  = '{3'b011, 1'b0, 32'h0,    3'b000, 1'b1, 1'b1, 2'd1};
        tbl[3]  = '{3'b011, 1'b1, 32'h1234, 3'b010, 1'b1, 1'b1, 2'd1};
        tbl[4]  = '{3'b011, 1'b0, 32'h0,    3'b000, 1'b1, 1'b0, 2'd0};
        tbl[5]  = '{3'b011, 1'b0, 32'h0,    3'b000, 1'b1, 1'b1, 2'd0};
        tbl[6]  = '{3'b011, 1'b1, 32'hA5A5, 3'b001, 1'b1, 1'b1, 2'd0};
        tbl[7]  = '{3'b000, 1'b0, 32'h0,    3'b000, 1'b0, 1'b0, 2'd0};
        tbl[8]  = '{3'b100, 1'b1, 32'h55,   3'b100, 1'b1, 1'b0, 2'd2};
        tbl[9]  = '{3'b110, 1'b1, 32'h66,   3'b010, 1'b1, 1'b0, 2'd1};
        tbl[10] = '{3'b111, 1'b0, 32'h0,    3'b000, 1'b1, 1'b0, 2'd2};
        tbl[11] = '{3'b011, 1'b1, 32'h0,    3'b000, 1'b0, 1'b1, 2'd2};
        tbl[12] = '{3'b111, 1'b1, 32'h77,   3'b100, 1'b1, 1'b0, 2'd2};
        tbl[13] = '{3'b000, 1'b1, 32'h0,    3'b000, 1'b0, 1'b0, 2'd0};

        rst_n     = 1'b0;
        s_req     = '0;
        m_grant   = 1'b0;
        m_payload = '0;
        mdl_reset();
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 14; i++) begin
            s_req     = tbl[i].req;
            m_grant   = tbl[i].mg;
            m_payload = tbl[i].pay;
            #4;
            check("tbl_s_grant", 32'(s_grant), 32'(tbl[i].g));
            check("tbl_m_req", 32'(m_req), 32'(tbl[i].mr));
            check("tbl_busy", 32'(busy), 32'(tbl[i].b));
            check("tbl_sel_id", 32'(sel_id), 32'(tbl[i].sel));
            check("tbl_s_payload", s_payload, tbl[i].pay);
            check("tbl_timeout_err", 32'(timeout_err), 32'd0);
            tick();
        end

        // Reset asserted in the third LOCK cycle of requester 1 (rr_ptr=1)
        drive_check(3'b001, 1'b1, eg); tick();
        drive_check(3'b011, 1'b0, eg); tick();
        drive_check(3'b011, 1'b0, eg); tick();
        drive_check(3'b011, 1'b0, eg); tick();
        s_req   = 3'b011;
        m_grant = 1'b0;
        #2;
        check("lockrst_busy_before", 32'(busy), 32'd1);
        check("lockrst_sel_before", 32'(sel_id), 32'd1);
        rst_n = 1'b0;
        #1;
        check("lockrst_busy", 32'(busy), 32'd0);
        check("lockrst_sel_id", 32'(sel_id), 32'd0);
        check("lockrst_grant", 32'(s_grant), 32'd0);
        mdl_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_check(3'b011, 1'b1, eg);
        check("lockrst_restart_grant", 32'(s_grant), 32'b001);
        tick();

        // Withdrawal in LOCK: no grant, pointer unchanged
        drive_check(3'b100, 1'b0, eg); tick();           // LOCK on requester 2
        drive_check(3'b001, 1'b1, eg);                   // requester 2 drops
        check("drop_no_grant", 32'(s_grant), 32'd0);
        check("drop_m_req", 32'(m_req), 32'd0);
        tick();
        drive_check(3'b111, 1'b1, eg);                   // pointer still 1
        check("drop_ptr_kept", 32'(s_grant), 32'b010);
        tick();

`ifdef REQ_GRANT_ARB_TIMEOUT_EN
        do_reset();
        drive_check(3'b001, 1'b0, eg); tick();
        for (int i = 0; i < TO; i++) begin
            drive_check(3'b001, 1'b0, eg);
            check("to_busy", 32'(busy), 32'd1);
            check("to_err_low", 32'(timeout_err), 32'd0);
            tick();
        end
        drive_check(3'b011, 1'b0, eg);
        check("to_err_set", 32'(timeout_err), 32'd1);
        check("to_idle", 32'(busy), 32'd0);
        check("to_ptr_adv", 32'(sel_id), 32'd1);
        tick();
        drive_check(3'b011, 1'b1, eg);
        check("to_err_sticky", 32'(timeout_err), 32'd1);
        tick();
        do_reset();
        check("to_err_cleared", 32'(timeout_err), 32'd0);
`else
        for (int i = 0; i < 12; i++) begin
            drive_check(3'b001, 1'b0, eg);
            if (i > 0) check("nto_wait_busy", 32'(busy), 32'd1);
            tick();
        end
        drive_check(3'b001, 1'b1, eg);
        check("nto_late_grant", 32'(s_grant), 32'b001);
        tick();
`endif

        // Randomized protocol-obedient traffic with fairness tracking
        do_reset();
        pend = '0;
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(2) == 0) pend[k] = 1'b1;
            end
            drive_check(pend, ($urandom_range(2) == 0), eg);
            if (eg != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (eg[k]) begin
                        check("fairness", 32'(wait_cnt[k] < N), 32'd1);
                        wait_cnt[k] = 0;
                        pend[k]     = 1'b0;
                    end else if (pend[k]) begin
                        wait_cnt[k]++;
                    end
                end
            end
            tick();
            if (md_to_owner >= 0) wait_cnt[md_to_owner] = 0;
        end

        // Unconstrained random traffic, including withdrawals
        for (int c = 0; c < 400; c++) begin
            drive_check(N'($urandom), 1'($urandom), eg);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
